// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory macro.
// slave = arbiter side, master = requesters plus memory model.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single-port memory: one access in flight,
// round-robin on ties, fixed MEM_LAT read latency, every output registered.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, CAPTURE} state_t;
    typedef enum logic {PORT_IF, PORT_D} port_t;

    state_t     state, state_n;
    port_t      last_owner;
    logic       sel_we;
    logic [2:0] cnt;
    logic       take;
    logic       pick_d;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A tie goes to whichever port did not own the previous access.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        pick_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    take    = 1'b1;
                    pick_d  = bus.d_req && (!bus.if_req || last_owner == PORT_IF);
                    state_n = ACCESS;
                end
            end
            ACCESS:  state_n = (MEM_LAT > 1) ? WAIT : CAPTURE;
            WAIT:    if (cnt == 3'd1) state_n = CAPTURE;
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are set on the edge that enters the state they belong to, so gnt/mem_en
    // are high during ACCESS and rvalid is high in the cycle after CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner    <= PORT_D;
            sel_we        <= 1'b0;
            cnt           <= '0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_gnt     <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;

            if (take) begin
                last_owner    <= pick_d ? PORT_D : PORT_IF;
                sel_we        <= pick_d && bus.d_we;
                bus.if_gnt    <= !pick_d;
                bus.d_gnt     <= pick_d;
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= pick_d && bus.d_we;
                bus.mem_addr  <= pick_d ? bus.d_addr : bus.if_addr;
                bus.mem_wdata <= pick_d ? bus.d_wdata : '0;
            end

            if (state == ACCESS)    cnt <= 3'(MEM_LAT - 1);
            else if (state == WAIT) cnt <= cnt - 3'd1;

            if (state == CAPTURE) begin
                if (last_owner == PORT_D) begin
                    bus.d_rvalid <= 1'b1;
                    bus.d_rdata  <= sel_we ? '0 : bus.mem_rdata;
                end else begin
                    bus.if_rvalid <= 1'b1;
                    bus.if_rdata  <= bus.mem_rdata;
                end
            end
        end
    end
endmodule
